// File: rtl/pe_multilane_accum.sv
// rtl/pe_multilane_accum.sv - multi-lane fp32 systolic PE with tile sequencing, abort and result handshake

// Two-stage fp32 multiply-add: y = a*b + c (or + internal acc when use_acc).
// Subnormal inputs are flushed to zero, overflow saturates to infinity,
// NaN is not propagated. The sum is rounded to nearest-even.
module fp32_mac (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic        use_acc,
    input  logic        clr_acc,
    output logic        valid_out,
    output logic [31:0] y
);
    logic [47:0]        w_prod;
    logic               w_p_zero;
    logic               w_p_sign;
    logic signed [10:0] w_p_exp;
    logic [26:0]        w_p_ext;

    logic               r_v1;
    logic               r_p_zero;
    logic               r_p_sign;
    logic signed [10:0] r_p_exp;
    logic [26:0]        r_p_ext;
    logic [31:0]        r_c;
    logic [31:0]        r_acc;
    logic [31:0]        r_y;
    logic               r_vout;

    logic               w_c_zero;
    logic signed [10:0] w_c_exp;
    logic [26:0]        w_c_ext;
    logic               w_swap;
    logic               w_b_sign;
    logic               w_s_sign;
    logic signed [10:0] w_b_exp;
    logic signed [10:0] w_s_exp;
    logic [26:0]        w_b_ext;
    logic [26:0]        w_s_ext;
    logic signed [10:0] w_shift;
    logic [26:0]        w_s_al;
    logic [27:0]        w_sum;
    logic [4:0]         w_lead;
    logic [26:0]        w_norm;
    logic [24:0]        w_rnd;
    logic signed [10:0] w_r_exp;
    logic [22:0]        w_frac;
    logic [31:0]        w_y;

    // Product: exponent sum and 27-bit significand (24 bits, 2 guard, 1 sticky)
    always_comb begin
        w_prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        w_p_zero = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
        w_p_sign = a[31] ^ b[31];
        w_p_exp  = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        w_p_ext  = {w_prod[46:21], |w_prod[20:0]};
        if (w_prod[47]) begin
            w_p_exp = w_p_exp + 11'sd1;
            w_p_ext = {w_prod[47:22], |w_prod[21:0]};
        end
    end

    // Stage 1 register: product and addend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_p_zero <= 1'b1;
            r_p_sign <= 1'b0;
            r_p_exp  <= '0;
            r_p_ext  <= '0;
            r_c      <= '0;
        end else begin
            r_v1 <= valid_in;
            if (valid_in) begin
                r_p_zero <= w_p_zero;
                r_p_sign <= w_p_sign;
                r_p_exp  <= w_p_exp;
                r_p_ext  <= w_p_ext;
                r_c      <= use_acc ? r_acc : c;
            end
        end
    end

    // Add: align smaller operand, add/subtract, normalise, round, pack
    always_comb begin
        w_c_zero = (r_c[30:23] == 8'd0);
        w_c_exp  = $signed({3'b000, r_c[30:23]});
        w_c_ext  = w_c_zero ? 27'd0 : {1'b1, r_c[22:0], 3'b000};
        w_swap   = !w_c_zero && ((w_c_exp > r_p_exp) ||
                   ((w_c_exp == r_p_exp) && (w_c_ext > r_p_ext)));
        if (w_swap) begin
            w_b_sign = r_c[31];  w_b_exp = w_c_exp;  w_b_ext = w_c_ext;
            w_s_sign = r_p_sign; w_s_exp = r_p_exp;  w_s_ext = r_p_ext;
        end else begin
            w_b_sign = r_p_sign; w_b_exp = r_p_exp;  w_b_ext = r_p_ext;
            w_s_sign = r_c[31];  w_s_exp = w_c_exp;  w_s_ext = w_c_ext;
        end
        w_shift = w_b_exp - w_s_exp;
        if (w_shift > 11'sd26) w_s_al = '0;
        else                   w_s_al = w_s_ext >> w_shift[4:0];
        if (w_b_sign == w_s_sign) w_sum = {1'b0, w_b_ext} + {1'b0, w_s_al};
        else                      w_sum = {1'b0, w_b_ext} - {1'b0, w_s_al};
        w_lead = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (w_sum[i]) w_lead = 5'(i);
        end
        if (w_lead >= 5'd26) w_norm = 27'(w_sum >> (w_lead - 5'd26));
        else                 w_norm = 27'(w_sum << (5'd26 - w_lead));
        w_rnd   = {1'b0, w_norm[26:3]} + {24'd0, w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0])};
        w_r_exp = w_b_exp + $signed({6'd0, w_lead}) - 11'sd26 + (w_rnd[24] ? 11'sd1 : 11'sd0);
        w_frac  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
        if (r_p_zero)              w_y = r_c;
        else if (w_sum == 28'd0)   w_y = 32'd0;
        else if (w_r_exp <= 11'sd0)   w_y = {w_b_sign, 31'd0};
        else if (w_r_exp >= 11'sd255) w_y = {w_b_sign, 8'hFF, 23'd0};
        else                       w_y = {w_b_sign, w_r_exp[7:0], w_frac};
    end

    // Stage 2 register: result, valid strobe and internal accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vout <= 1'b0;
            r_y    <= '0;
            r_acc  <= '0;
        end else begin
            r_vout <= r_v1;
            if (r_v1) r_y <= w_y;
            if (clr_acc)   r_acc <= '0;
            else if (r_v1) r_acc <= w_y;
        end
    end

    assign valid_out = r_vout;
    assign y         = r_y;
endmodule

module pe_multilane_accum #(
    parameter int LANES = 4,
    parameter int K_MAX = 64,
    parameter int CNT_W = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           x_i,
    input  logic [32*LANES-1:0]   w_i,
    input  logic [CNT_W-1:0]      k_len,
    input  logic                  clr,
    output logic [31:0]           x_o,
    output logic [32*LANES-1:0]   w_o,
    output logic                  fwd_valid,
    output logic [32*LANES-1:0]   psum_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [15:0]           tile_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCEPT, S_DRAIN, S_FLUSH} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_step;
    logic [CNT_W-1:0]      r_k;
    logic [32*LANES-1:0]   r_acc;
    logic [CNT_W-1:0]      w_k_new;
    logic                  w_accept;
    logic                  w_first;
    logic                  w_vout;
    logic                  w_tile_done;
    logic                  w_rst_n;
    logic [LANES-1:0]      w_lane_vout;
    logic [32*LANES-1:0]   w_y;
    logic [32*LANES-1:0]   w_c;

    assign w_rst_n  = ~rst;
    assign in_ready = (r_state == S_IDLE) || (r_state == S_ACCEPT) ||
                      ((r_state == S_DRAIN) && out_ready);
    // clr wins over an accept in the same cycle: nothing is issued or forwarded
    assign w_accept = in_valid && in_ready && !clr;
    assign w_first  = (r_state == S_IDLE) || (r_state == S_DRAIN);
    assign w_k_new  = (k_len == '0) ? CNT_W'(1) :
                      ((k_len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len);
    // Lanes share reset and issue strobe, so they complete in lockstep
    assign w_vout   = &w_lane_vout;
    assign out_valid = (r_state == S_DRAIN);
    assign busy      = (r_state != S_IDLE);
    assign psum_o    = r_acc;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_c[32*l +: 32] = w_first ? 32'd0 : r_acc[32*l +: 32];
        fp32_mac u_mac (
            .clk       (clk),
            .rst_n     (w_rst_n),
            .valid_in  (w_accept),
            .a         (x_i),
            .b         (w_i[32*l +: 32]),
            .c         (w_c[32*l +: 32]),
            .use_acc   (1'b0),
            .clr_acc   (1'b0),
            .valid_out (w_lane_vout[l]),
            .y         (w_y[32*l +: 32])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and tile hand-off decode
    always_comb begin
        w_next      = r_state;
        w_tile_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_WAIT;
            end
            S_WAIT: begin
                // A result landing in the abort cycle is already out, so skip FLUSH
                if (clr)         w_next = w_vout ? S_IDLE : S_FLUSH;
                else if (w_vout) w_next = ((r_step + CNT_W'(1)) == r_k) ? S_DRAIN : S_ACCEPT;
            end
            S_ACCEPT: begin
                if (clr)           w_next = S_IDLE;
                else if (w_accept) w_next = S_WAIT;
            end
            S_DRAIN: begin
                if (clr) begin
                    w_next = S_IDLE;
                end else if (out_ready) begin
                    w_tile_done = 1'b1;
                    w_next      = w_accept ? S_WAIT : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_vout) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: forwarding, tile length latch, step counter, accumulators, tile count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step    <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            x_o       <= '0;
            w_o       <= '0;
            fwd_valid <= 1'b0;
            tile_cnt  <= '0;
        end else begin
            fwd_valid <= w_accept;
            if (w_accept) begin
                x_o <= x_i;
                w_o <= w_i;
                if (w_first) begin
                    r_k    <= w_k_new;
                    r_step <= '0;
                end
            end
            if ((r_state == S_WAIT) && w_vout && !clr) begin
                r_acc  <= w_y;
                r_step <= r_step + CNT_W'(1);
            end
            if (w_tile_done) tile_cnt <= tile_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pe_multilane_accum.sv
// tb/tb_pe_multilane_accum.sv - directed vector bench for pe_multilane_accum
`timescale 1ns/1ps
module tb_pe_multilane_accum;
    localparam int LANES = 4;
    localparam int K_MAX = 64;
    localparam int CNT_W = 7;

    typedef struct {
        logic [CNT_W-1:0] k;
        logic [31:0]      x;
        logic [127:0]     w;
        int               steps;
        int               hold;
        logic [127:0]     psum;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        x_i;
    logic [127:0]       w_i;
    logic [CNT_W-1:0]   k_len;
    logic               clr;
    logic [31:0]        x_o;
    logic [127:0]       w_o;
    logic               fwd_valid;
    logic [127:0]       psum_o;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic [15:0]        tile_cnt;

    int           errors = 0;
    int           checks = 0;
    int           fwd_cnt = 0;
    int           seen_ov = 0;
    int           exp_tiles = 0;
    logic         chk_fwd = 1'b0;
    logic [31:0]  exp_x = '0;
    logic [127:0] exp_w = '0;
    vec_t         vecs[5];
    vec_t         v;

    pe_multilane_accum #(.LANES(LANES), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_i(x_i), .w_i(w_i), .k_len(k_len), .clr(clr),
        .x_o(x_o), .w_o(w_o), .fwd_valid(fwd_valid), .psum_o(psum_o),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (fwd_valid) begin
            fwd_cnt++;
            if (chk_fwd) begin
                check("fwd_x", x_o, exp_x);
                check("fwd_w", w_o, exp_w);
            end
        end
        if (out_valid) seen_ov = 1;
    endtask

    task automatic wait_fwd(input int n);
        int t = 0;
        while (fwd_cnt < n && t < 40) begin tick(); t++; end
        check("fwd_wait", fwd_cnt, n);
    endtask

    task automatic to_drain(input vec_t tv, input string tag);
        int t = 0;
        k_len = tv.k; x_i = tv.x; w_i = tv.w;
        exp_x = tv.x; exp_w = tv.w; chk_fwd = 1'b1;
        fwd_cnt = 0; out_ready = 1'b0; in_valid = 1'b1;
        while (!out_valid && t < tv.steps * 6 + 20) begin tick(); t++; end
        check({tag, "_drain"}, out_valid, 1);
        check({tag, "_steps"}, fwd_cnt, tv.steps);
        check({tag, "_psum"}, psum_o, tv.psum);
        check({tag, "_ready"}, in_ready, 0);
        for (int i = 0; i < tv.hold; i++) begin
            tick();
            check({tag, "_hold_ov"}, out_valid, 1);
            check({tag, "_hold_psum"}, psum_o, tv.psum);
            check({tag, "_hold_rdy"}, in_ready, 0);
        end
    endtask

    task automatic release_tile(input string tag);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        exp_tiles++;
        check({tag, "_tiles"}, tile_cnt, exp_tiles);
        check({tag, "_idle_ov"}, out_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        // lane l = bits [32l+31:32l]; literals are written lane3..lane0
        vecs[0] = '{7'd3,  32'h40000000, 128'h40800000_40400000_40000000_3F800000, 3, 5,
                    128'h41C00000_41900000_41400000_40C00000};
        vecs[1] = '{7'd0,  32'h40400000, 128'h3F800000_3F800000_3F800000_3F800000, 1, 0,
                    128'h40400000_40400000_40400000_40400000};
        vecs[2] = '{7'd2,  32'h3FC00000, 128'h40800000_00000000_3F000000_C0000000, 2, 0,
                    128'h41400000_00000000_3FC00000_C0C00000};
        vecs[3] = '{7'd69, 32'h3F800000, 128'h3E800000_3F000000_40000000_3F800000, 64, 0,
                    128'h41800000_42000000_43000000_42800000};
        vecs[4] = '{7'd4,  32'h3F000000, 128'h3F800000_41000000_40400000_BF800000, 4, 1,
                    128'h40000000_41800000_40C00000_C0000000};

        rst = 1'b1; in_valid = 1'b0; x_i = '0; w_i = '0; k_len = '0; clr = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_ov", out_valid, 0);
        check("rst_psum", psum_o, 0);
        check("rst_tiles", tile_cnt, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Tile with a different activation each step
        k_len = 7'd3; w_i = 128'h40800000_40400000_40000000_3F800000; exp_w = w_i;
        out_ready = 1'b0; fwd_cnt = 0; chk_fwd = 1'b1;
        x_i = 32'h3F800000; exp_x = x_i; in_valid = 1'b1;
        wait_fwd(1);
        x_i = 32'h40000000; exp_x = x_i;
        wait_fwd(2);
        x_i = 32'h40400000; exp_x = x_i;
        wait_fwd(3);
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        check("t1_drain", out_valid, 1);
        check("t1_psum", psum_o, 128'h41C00000_41900000_41400000_40C00000);
        check("t1_fwd", fwd_cnt, 3);
        release_tile("t1");

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            to_drain(vecs[i], $sformatf("vec%0d", i));
            release_tile($sformatf("vec%0d", i));
        end

        // Zero-bubble chaining out of DRAIN
        to_drain(vecs[0], "chain_a");
        k_len = 7'd1; x_i = 32'h40000000; w_i = {4{32'h3F800000}};
        exp_x = x_i; exp_w = w_i; fwd_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        exp_tiles++;
        check("chain_tiles", tile_cnt, exp_tiles);
        check("chain_busy", busy, 1);
        check("chain_ov", out_valid, 0);
        check("chain_fwd", fwd_cnt, 1);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        check("chain_drain", out_valid, 1);
        check("chain_psum", psum_o, {4{32'h40000000}});
        check("chain_steps", fwd_cnt, 1);
        release_tile("chain_b");

        // Abort while a MAC is in flight
        k_len = 7'd4; x_i = 32'h3F800000; w_i = {4{32'h3F800000}};
        exp_x = x_i; exp_w = w_i; fwd_cnt = 0; seen_ov = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        wait_fwd(1);
        clr = 1'b1; in_valid = 1'b0;
        tick();
        clr = 1'b0;
        check("flush_busy", busy, 1);
        check("flush_ready", in_ready, 0);
        for (int t = 0; t < 10 && busy; t++) tick();
        check("flush_idle", busy, 0);
        tick(); tick(); tick();
        check("flush_no_ov", seen_ov, 0);
        check("flush_tiles", tile_cnt, exp_tiles);
        v = '{7'd1, 32'h3F800000, {4{32'h3F800000}}, 1, 0, {4{32'h3F800000}}};
        to_drain(v, "post_flush");
        release_tile("post_flush");

        // Abort in DRAIN, then clr with in_valid while idle
        to_drain(vecs[1], "clr_drain");
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("clr_drain_ov", out_valid, 0);
        check("clr_drain_busy", busy, 0);
        check("clr_drain_tiles", tile_cnt, exp_tiles);
        out_ready = 1'b0; fwd_cnt = 0; in_valid = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_idle_fwd", fwd_cnt, 0);
        check("clr_idle_busy", busy, 0);
        tick();

        // Asynchronous reset in the middle of WAIT
        k_len = 7'd4; x_i = 32'h3F800000; w_i = {4{32'h40000000}};
        exp_x = x_i; exp_w = w_i; fwd_cnt = 0; in_valid = 1'b1;
        wait_fwd(1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_fwd", fwd_valid, 0);
        check("arst_ov", out_valid, 0);
        check("arst_psum", psum_o, 0);
        check("arst_tiles", tile_cnt, 0);
        check("arst_xo", x_o, 0);
        check("arst_wo", w_o, 0);
        exp_tiles = 0; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        check("arst_stale", busy, 0);
        to_drain(vecs[2], "post_rst");
        release_tile("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_multilane_accum.md
Name: pe_multilane_accum

Overview:
Next-generation systolic processing element. It holds LANES independent fp32 accumulators that share one broadcast activation, so each lane computes acc[l] += x*w[l]. Each tile runs for a programmable number of steps, k_len. The block forwards operands to its neighbours with a valid strobe, presents results through a valid/ready handshake with backpressure, and supports a synchronous abort that flushes an in-flight MAC. It sits in the array fabric in place of the single-lane PE and uses one fp32_mac instance per lane.

Parameters:
LANES, 4, number of parallel MAC lanes/accumulators
K_MAX, 64, maximum accumulation length per tile
CNT_W, $clog2(K_MAX+1), width of k_len and the step counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand set valid
in_ready  out  1  PE can accept an operand set this cycle
x_i  in  32  activation (word_t), broadcast to all lanes
w_i  in  32*LANES  weights; lane l = bits [32l+31:32l]
k_len  in  CNT_W  tile length; sampled on the first accept of a tile
clr  in  1  synchronous abort
x_o  out  32  registered forwarded activation
w_o  out  32*LANES  registered forwarded weights
fwd_valid  out  1  one-cycle pulse: x_o/w_o updated
psum_o  out  32*LANES  accumulated result, lane-packed like w_i
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
busy  out  1  state != IDLE
tile_cnt  out  16  completed (handed-off) tiles, wraps at 2^16

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; acc, x_o, w_o, step counter, latched k, tile_cnt all 0. fwd_valid=0, out_valid=0. Each fp32_mac gets rst_n = ~rst.
- Accept = in_valid && in_ready. On accept:
  - issue valid_in=1 to all lanes with a=x_i, b=w_i[l], c=(first step ? 0 : acc[l]), use_acc=0, clr_acc=0.
  - x_o<=x_i and w_o<=w_i; fwd_valid=1 on the next cycle only.
- All lanes issue together, so completion is decided by lane 0 valid_out.
- States:
  - IDLE: in_ready=1. On accept: latch k = (k_len==0) ? 1 : min(k_len, K_MAX); step=0; go WAIT.
  - WAIT: in_ready=0. On valid_out: acc[l]<=y[l]; step++. If step+1==k go DRAIN, else go ACCEPT.
  - ACCEPT: in_ready=1. On accept: issue with c=acc; go WAIT.
  - DRAIN: out_valid=1, psum_o=acc (stable while out_valid && !out_ready). in_ready=out_ready.
    - out_ready && !in_valid: tile_cnt++; go IDLE.
    - out_ready && in_valid: tile_cnt++ and accept the first step of a new tile in the same cycle (latch new k, c=0); go WAIT. Zero-bubble tile chaining.
  - FLUSH: in_ready=0, out_valid=0. On valid_out: discard y; go IDLE.
- psum_o holds the last acc outside DRAIN.
- clr (has priority over all other transitions):
  - in WAIT, go FLUSH;
  - in ACCEPT or DRAIN, go IDLE with no tile_cnt increment and out_valid dropped next cycle;
  - in IDLE, no effect. An accept in the same cycle as clr is ignored (no MAC issue, no forward).
- At most one MAC in flight per lane. valid_out outside WAIT/FLUSH is ignored.
- Latency per step = fp32_mac latency + 1 cycle back to ACCEPT. Result appears in DRAIN one cycle after the last valid_out.

Test Plan:
1. LANES=4, k_len=3; x=1.0,2.0,3.0; w[l]=(l+1).0 every step -> one DRAIN with psum_o = 6.0,12.0,18.0,24.0 (0x40C00000,0x41400000,0x41900000,0x41C00000); tile_cnt=1; exactly 3 fwd_valid pulses carrying matching x_o/w_o.
2. Case 1 with out_ready=0 for 5 cycles in DRAIN -> out_valid and psum_o stable, in_ready=0; out_ready=1 -> IDLE, tile_cnt=1.
3. DRAIN with out_ready=1 and in_valid=1, new tile k_len=1, x=2.0, w=1.0 -> same-cycle accept; next psum_o=2.0 per lane (c=0, no carry-over); tile_cnt=2.
4. k_len=0 -> exactly 1 step accepted, then DRAIN. k_len=K_MAX+5 (CNT_W allowing) -> exactly K_MAX steps before DRAIN.
5. clr asserted in WAIT of a k_len=4 tile -> FLUSH until valid_out, then IDLE; out_valid never rises, tile_cnt unchanged. Next tile from 1.0*1.0 yields 1.0.
6. rst pulsed asynchronously mid-WAIT (between clock edges) -> all outputs zero immediately. Stale MAC completion ignored; a fresh tile computes correctly.
